memory_arbiter_16entry_256bit: RTL and testbench
================================================

MEMORY_ARBITER_16ENTRY_256BIT -- requirements
Module: memory_arbiter_16entry_256bit

Interface
REQ-001 SHALL have parameter P_FIXED_PRIORITY, default 0; 0 = round-robin, 1 = requester A always wins.
REQ-002 SHALL have one clock and asynchronous active-low reset: iCLOCK in 1 (all state on rising edge); inRESET in 1 (active-low async reset).
REQ-003 SHALL provide, per requester x in {A,B}: ix_REQ in 1 (request); ox_BUSY out 1 (request not accepted this cycle); ix_RW in 1 (1 = write, 0 = read); ix_ADDR in 4 (entry); ix_BYTE_ENA in 32 (byte enables, write only); ix_DATA in 256 (write data).
REQ-004 SHALL provide, per requester x: ox_VALID out 1 (one-cycle completion pulse); ox_DATA out 256 (read data, meaningful only while ox_VALID and read).
REQ-005 SHALL provide memory side: oMEM_WR_ENA out 1; oMEM_WR_ADDR out 4; oMEM_BYTE_ENA out 32; oMEM_WR_DATA out 256; oMEM_RD_ADDR out 4; iMEM_RD_DATA in 256 (asynchronous read of oMEM_RD_ADDR).

Function
REQ-006 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; one transaction in flight; throughput one per 3 cycles.
REQ-007 Acceptance SHALL occur only in IDLE, on a cycle where ix_REQ=1 and ox_BUSY=0; on acceptance: latch RW, ADDR, BYTE_ENA, DATA, owner; go to EXEC.
REQ-008 ox_BUSY SHALL be 1 whenever state != IDLE, and 1 in IDLE when the other requester is granted that cycle; otherwise 0 (combinational from requests and pointer).
REQ-009 Requester SHALL hold iREQ and fields stable until accepted; non-accepted cycles have no effect.
REQ-010 Round-robin: if both request in IDLE, the requester not granted last wins; pointer updates only on acceptance; a lone requester wins regardless of pointer.
REQ-011 P_FIXED_PRIORITY=1: A wins all ties; pointer ignored.
REQ-012 EXEC, write: oMEM_WR_ENA=1 for exactly that cycle with latched addr/byte-enables/data; byte-merge is done by the memory.
REQ-013 EXEC, read: oMEM_RD_ADDR=latched addr, oMEM_WR_ENA=0; iMEM_RD_DATA captured into read register at end of EXEC.
REQ-014 RESP: owner's ox_VALID=1 for exactly one cycle; for reads ox_DATA = captured data; for writes ox_DATA = 0; other requester's ox_VALID=0.
REQ-015 oMEM_WR_ENA SHALL be 0 in IDLE and RESP; memory addr/data outputs hold last latched values outside EXEC.
REQ-016 Write of all-zero BYTE_ENA SHALL still run full sequence (WR_ENA pulse, VALID pulse); memory unchanged.
REQ-017 Read accepted immediately after write to same entry SHALL return post-write data (serialization guarantees order).
REQ-018 Requests arriving during EXEC/RESP SHALL see BUSY=1 and be arbitrated in the IDLE cycle following RESP.
REQ-019 Addresses 0..15 all valid; no wrap or out-of-range case exists.

Reset
REQ-020 inRESET=0 SHALL asynchronously force: state IDLE, pointer favoring A, oMEM_WR_ENA=0, oA_VALID=oB_VALID=0, oA_DATA=oB_DATA=0, latched command/address/data registers 0.
REQ-021 Reset during EXEC or RESP SHALL abort the transaction: no VALID pulse issued; a write aborted in EXEC may or may not have reached memory only if reset deasserts after the edge; no WR_ENA after reset assertion.
REQ-022 First cycle after reset release SHALL be IDLE and accept requests.

Verification
REQ-023 A write addr 3, BYTE_ENA=0xFFFFFFFF, data pattern P -> WR_ENA at cycle+1, oA_VALID at cycle+2; A read addr 3 -> oA_VALID with oA_DATA=P.
REQ-024 Partial write BYTE_ENA=0x0000000F data all-ones over entry of zeros, then read -> data bits[31:0]=0xFFFFFFFF, rest 0.
REQ-025 A and B request continuously, round-robin -> grants alternate A,B,A,B starting with A after reset; each VALID goes to correct owner; with P_FIXED_PRIORITY=1 B starves while A requests.
REQ-026 B requests while A in EXEC -> oB_BUSY=1 through RESP; B accepted in next IDLE cycle.
REQ-027 Assert inRESET mid-EXEC of a read -> no VALID pulse, outputs zero immediately, fresh request accepted the first cycle after release.
REQ-028 Write BYTE_ENA=0 to entry holding Q, then read -> data Q, both VALID pulses present.

Source files
------------

// File: rtl/memory_arbiter_16entry_256bit.sv
// Two-requester arbiter for a 16x256 memory: IDLE->EXEC->RESP, one access per 3 cycles, VALID two cycles after accept.
// Backpressure: ox_BUSY is combinational; high outside IDLE or when the other requester wins the IDLE cycle.
module memory_arbiter_16entry_256bit #(
    parameter int P_FIXED_PRIORITY = 0
) (
    input  logic         iCLOCK,
    input  logic         inRESET,
    input  logic         iA_REQ,
    output logic         oA_BUSY,
    input  logic         iA_RW,
    input  logic [3:0]   iA_ADDR,
    input  logic [31:0]  iA_BYTE_ENA,
    input  logic [255:0] iA_DATA,
    output logic         oA_VALID,
    output logic [255:0] oA_DATA,
    input  logic         iB_REQ,
    output logic         oB_BUSY,
    input  logic         iB_RW,
    input  logic [3:0]   iB_ADDR,
    input  logic [31:0]  iB_BYTE_ENA,
    input  logic [255:0] iB_DATA,
    output logic         oB_VALID,
    output logic [255:0] oB_DATA,
    output logic         oMEM_WR_ENA,
    output logic [3:0]   oMEM_WR_ADDR,
    output logic [31:0]  oMEM_BYTE_ENA,
    output logic [255:0] oMEM_WR_DATA,
    output logic [3:0]   oMEM_RD_ADDR,
    input  logic [255:0] iMEM_RD_DATA
);

    localparam logic [1:0] L_IDLE = 2'd0;
    localparam logic [1:0] L_EXEC = 2'd1;
    localparam logic [1:0] L_RESP = 2'd2;

    logic [1:0]   state;
    logic         rrFavorB;
    logic         owner;
    logic         cmdRw;
    logic [3:0]   cmdAddr;
    logic [31:0]  cmdByteEna;
    logic [255:0] cmdData;
    logic [255:0] rdData;
    logic         isIdle;
    logic         grantA;
    logic         grantB;

    assign isIdle = (state == L_IDLE);

    always_comb begin
        grantA = 1'b0;
        grantB = 1'b0;
        if (isIdle) begin
            if (P_FIXED_PRIORITY != 0) begin
                grantA = iA_REQ;
                grantB = iB_REQ & ~iA_REQ;
            end else begin
                // A lone requester wins; on a tie the pointer picks.
                grantA = iA_REQ & (~iB_REQ | ~rrFavorB);
                grantB = iB_REQ & (~iA_REQ | rrFavorB);
            end
        end
    end

    assign oA_BUSY = ~isIdle | grantB;
    assign oB_BUSY = ~isIdle | grantA;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state      <= L_IDLE;
            rrFavorB   <= 1'b0;
            owner      <= 1'b0;
            cmdRw      <= 1'b0;
            cmdAddr    <= '0;
            cmdByteEna <= '0;
            cmdData    <= '0;
            rdData     <= '0;
        end else begin
            case (state)
                L_IDLE: begin
                    if (grantA | grantB) begin
                        owner      <= grantB;
                        cmdRw      <= grantB ? iB_RW       : iA_RW;
                        cmdAddr    <= grantB ? iB_ADDR     : iA_ADDR;
                        cmdByteEna <= grantB ? iB_BYTE_ENA : iA_BYTE_ENA;
                        cmdData    <= grantB ? iB_DATA     : iA_DATA;
                        rrFavorB   <= grantA;
                        state      <= L_EXEC;
                    end
                end
                L_EXEC: begin
                    if (!cmdRw) begin
                        rdData <= iMEM_RD_DATA;
                    end
                    state <= L_RESP;
                end
                L_RESP:  state <= L_IDLE;
                default: state <= L_IDLE;
            endcase
        end
    end

    // Memory-side fields come straight from the command latch so they hold outside EXEC.
    assign oMEM_WR_ENA   = (state == L_EXEC) & cmdRw;
    assign oMEM_WR_ADDR  = cmdAddr;
    assign oMEM_RD_ADDR  = cmdAddr;
    assign oMEM_BYTE_ENA = cmdByteEna;
    assign oMEM_WR_DATA  = cmdData;

    assign oA_VALID = (state == L_RESP) & ~owner;
    assign oB_VALID = (state == L_RESP) & owner;
    assign oA_DATA  = (oA_VALID & ~cmdRw) ? rdData : '0;
    assign oB_DATA  = (oB_VALID & ~cmdRw) ? rdData : '0;

endmodule

// File: tb/tb_memory_arbiter_16entry_256bit.sv
// Scoreboard bench for memory_arbiter_16entry_256bit with a byte-enabled 16x256 memory model.
module tb_memory_arbiter_16entry_256bit;

    typedef struct packed {
        logic         owner;
        logic [255:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN, memClr;
    logic aReq, aRw, bReq, bRw;
    logic [3:0] aAddr, bAddr;
    logic [31:0] aBe, bBe;
    logic [255:0] aData, bData;
    logic aBusy, bBusy, aValid, bValid;
    logic [255:0] aDout, bDout;
    logic mWrEna;
    logic [3:0] mWrAddr, mRdAddr;
    logic [31:0] mBe;
    logic [255:0] mWrData, mRdData;

    logic fAReq, fBReq, fABusy, fBBusy, fAValid, fBValid, fWrEna;
    logic [255:0] fADout, fBDout, fWrData;
    logic [3:0] fWrAddr, fRdAddr;
    logic [31:0] fBe;

    logic [255:0] mem [16];
    logic [255:0] refMem [16];
    exp_t sbq [$];
    int checks = 0;
    int errors = 0;

    memory_arbiter_16entry_256bit #(.P_FIXED_PRIORITY(0)) dut (
        .iCLOCK(clk), .inRESET(rstN),
        .iA_REQ(aReq), .oA_BUSY(aBusy), .iA_RW(aRw), .iA_ADDR(aAddr), .iA_BYTE_ENA(aBe), .iA_DATA(aData),
        .oA_VALID(aValid), .oA_DATA(aDout),
        .iB_REQ(bReq), .oB_BUSY(bBusy), .iB_RW(bRw), .iB_ADDR(bAddr), .iB_BYTE_ENA(bBe), .iB_DATA(bData),
        .oB_VALID(bValid), .oB_DATA(bDout),
        .oMEM_WR_ENA(mWrEna), .oMEM_WR_ADDR(mWrAddr), .oMEM_BYTE_ENA(mBe), .oMEM_WR_DATA(mWrData),
        .oMEM_RD_ADDR(mRdAddr), .iMEM_RD_DATA(mRdData)
    );

    memory_arbiter_16entry_256bit #(.P_FIXED_PRIORITY(1)) dutF (
        .iCLOCK(clk), .inRESET(rstN),
        .iA_REQ(fAReq), .oA_BUSY(fABusy), .iA_RW(1'b0), .iA_ADDR(4'd1), .iA_BYTE_ENA(32'h0), .iA_DATA(256'h0),
        .oA_VALID(fAValid), .oA_DATA(fADout),
        .iB_REQ(fBReq), .oB_BUSY(fBBusy), .iB_RW(1'b0), .iB_ADDR(4'd2), .iB_BYTE_ENA(32'h0), .iB_DATA(256'h0),
        .oB_VALID(fBValid), .oB_DATA(fBDout),
        .oMEM_WR_ENA(fWrEna), .oMEM_WR_ADDR(fWrAddr), .oMEM_BYTE_ENA(fBe), .oMEM_WR_DATA(fWrData),
        .oMEM_RD_ADDR(fRdAddr), .iMEM_RD_DATA(256'h0)
    );

    always @(posedge clk) begin
        if (memClr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (mWrEna) begin
            for (int b = 0; b < 32; b++)
                if (mBe[b]) mem[mWrAddr][8*b +: 8] <= mWrData[8*b +: 8];
        end
    end
    assign mRdData = mem[mRdAddr];

    function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] d, input logic [31:0] be);
        logic [255:0] r;
        r = old;
        for (int b = 0; b < 32; b++)
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic present(input logic who, input logic rw, input logic [3:0] addr, input logic [31:0] be, input logic [255:0] d);
        if (!who) begin aReq = 1'b1; aRw = rw; aAddr = addr; aBe = be; aData = d; end
        else      begin bReq = 1'b1; bRw = rw; bAddr = addr; bBe = be; bData = d; end
    endtask

    task automatic push_exp(input logic who, input logic rw, input logic [3:0] addr, input logic [31:0] be, input logic [255:0] d);
        exp_t e;
        e.owner = who;
        if (rw) begin
            refMem[addr] = merge(refMem[addr], d, be);
            e.data = '0;
        end else begin
            e.data = refMem[addr];
        end
        sbq.push_back(e);
    endtask

    // Presents a request and waits for acceptance; returns at the negedge of the EXEC cycle.
    task automatic issue(input logic who, input logic rw, input logic [3:0] addr, input logic [31:0] be,
                         input logic [255:0] d, output bit ok, output int waitN);
        @(negedge clk);
        present(who, rw, addr, be, d);
        ok = 1'b0;
        waitN = 0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (!(who ? bBusy : aBusy)) begin
                ok = 1'b1;
                push_exp(who, rw, addr, be, d);
                break;
            end
            @(negedge clk);
            waitN++;
        end
        @(negedge clk);
        if (!who) aReq = 1'b0; else bReq = 1'b0;
    endtask

    task automatic wait_resp(output logic gA, output logic gB, output logic [255:0] dA, output logic [255:0] dB,
                             output int n, output bit to);
        to = 1'b1; gA = 1'b0; gB = 1'b0; dA = '0; dB = '0; n = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (aValid || bValid) begin
                gA = aValid; gB = bValid; dA = aDout; dB = bDout; n = i; to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0; memClr = 1'b1;
        aReq = 0; aRw = 0; aAddr = 0; aBe = 0; aData = 0;
        bReq = 0; bRw = 0; bAddr = 0; bBe = 0; bData = 0;
        fAReq = 0; fBReq = 0;
        for (int i = 0; i < 16; i++) refMem[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (aValid !== 1'b0 || bValid !== 1'b0) begin errors++; $display("FAIL rst_valid got A=%b B=%b exp 0 0", aValid, bValid); end
        checks++; if (aDout !== '0) begin errors++; $display("FAIL rst_a_data got %h exp 0", aDout); end
        checks++; if (bDout !== '0) begin errors++; $display("FAIL rst_b_data got %h exp 0", bDout); end
        checks++; if (mWrEna !== 1'b0) begin errors++; $display("FAIL rst_wr_ena got %b exp 0", mWrEna); end
        checks++; if (mWrAddr !== 4'd0 || mBe !== 32'd0 || mWrData !== '0) begin errors++; $display("FAIL rst_latch got addr=%h be=%h data=%h exp 0", mWrAddr, mBe, mWrData); end
        checks++; if (aBusy !== 1'b0 || bBusy !== 1'b0) begin errors++; $display("FAIL rst_busy got A=%b B=%b exp 0 0", aBusy, bBusy); end
        @(negedge clk);
        rstN = 1'b1; memClr = 1'b0;
    endtask

    task automatic test_write_read();
        logic [255:0] p;
        logic gA, gB; logic [255:0] dA, dB; int n, w; bit ok, to; exp_t e;
        p = {8{32'hA5C3_0F96}} ^ {32{8'h11}};
        issue(1'b0, 1'b1, 4'd3, 32'hFFFF_FFFF, p, ok, w);
        #1;
        checks++; if (!ok || w != 0) begin errors++; $display("FAIL wr_accept got ok=%0b wait=%0d exp 1 0", ok, w); end
        checks++; if (mWrEna !== 1'b1 || mWrAddr !== 4'd3 || mBe !== 32'hFFFF_FFFF || mWrData !== p) begin
            errors++; $display("FAIL wr_exec got ena=%b addr=%h be=%h data=%h exp 1 3 ffffffff %h", mWrEna, mWrAddr, mBe, mWrData, p); end
        checks++; if (aBusy !== 1'b1) begin errors++; $display("FAIL wr_exec_busy got %b exp 1", aBusy); end
        wait_resp(gA, gB, dA, dB, n, to);
        checks++; if (n != 0) begin errors++; $display("FAIL wr_valid_latency got %0d exp 0", n); end
        checks++; if (mWrEna !== 1'b0) begin errors++; $display("FAIL wr_resp_ena got %b exp 0", mWrEna); end
        e = 'x; if (sbq.size() > 0) e = sbq.pop_front();
        checks++; if (to || {gA, gB} !== (e.owner ? 2'b01 : 2'b10) || (e.owner ? dB : dA) !== e.data) begin
            errors++; $display("FAIL wr_resp got to=%0b A=%0b B=%0b data=%h exp owner=%0b data=%h", to, gA, gB, e.owner ? dB : dA, e.owner, e.data); end
        issue(1'b0, 1'b0, 4'd3, 32'h0, 256'h0, ok, w);
        #1;
        checks++; if (!ok || mWrEna !== 1'b0 || mRdAddr !== 4'd3) begin errors++; $display("FAIL rd_exec got ok=%0b ena=%b addr=%h exp 1 0 3", ok, mWrEna, mRdAddr); end
        wait_resp(gA, gB, dA, dB, n, to);
        e = 'x; if (sbq.size() > 0) e = sbq.pop_front();
        checks++; if (to || {gA, gB} !== (e.owner ? 2'b01 : 2'b10) || (e.owner ? dB : dA) !== e.data) begin
            errors++; $display("FAIL rd_resp got to=%0b A=%0b B=%0b data=%h exp owner=%0b data=%h", to, gA, gB, e.owner ? dB : dA, e.owner, e.data); end
        checks++; if (dA !== p) begin errors++; $display("FAIL rd_pattern got %h exp %h", dA, p); end
    endtask

    task automatic test_partial();
        logic [255:0] want;
        logic gA, gB; logic [255:0] dA, dB; int n, w; bit ok, to; exp_t e;
        want = {224'h0, 32'hFFFF_FFFF};
        issue(1'b0, 1'b1, 4'd5, 32'h0000_000F, {256{1'b1}}, ok, w);
        wait_resp(gA, gB, dA, dB, n, to);
        e = 'x; if (sbq.size() > 0) e = sbq.pop_front();
        checks++; if (!ok || to || {gA, gB} !== 2'b10 || dA !== e.data) begin
            errors++; $display("FAIL part_wr got ok=%0b to=%0b A=%0b B=%0b data=%h exp %h", ok, to, gA, gB, dA, e.data); end
        issue(1'b1, 1'b0, 4'd5, 32'h0, 256'h0, ok, w);
        wait_resp(gA, gB, dA, dB, n, to);
        e = 'x; if (sbq.size() > 0) e = sbq.pop_front();
        checks++; if (!ok || to || {gA, gB} !== 2'b01 || dB !== e.data) begin
            errors++; $display("FAIL part_rd got ok=%0b to=%0b A=%0b B=%0b data=%h exp %h", ok, to, gA, gB, dB, e.data); end
        checks++; if (dB !== want) begin errors++; $display("FAIL part_value got %h exp %h", dB, want); end
    endtask

    task automatic test_zero_be();
        logic [255:0] q;
        logic gA, gB; logic [255:0] dA, dB; int n, w; bit ok, to; exp_t e;
        q = {4{64'h0123_4567_89AB_CDEF}};
        issue(1'b1, 1'b1, 4'd7, 32'hFFFF_FFFF, q, ok, w);
        wait_resp(gA, gB, dA, dB, n, to);
        e = 'x; if (sbq.size() > 0) e = sbq.pop_front();
        checks++; if (!ok || to || {gA, gB} !== 2'b01 || dB !== e.data) begin
            errors++; $display("FAIL zbe_setup got ok=%0b to=%0b A=%0b B=%0b data=%h", ok, to, gA, gB, dB); end
        issue(1'b0, 1'b1, 4'd7, 32'h0, ~q, ok, w);
        #1;
        checks++; if (mWrEna !== 1'b1 || mBe !== 32'h0) begin errors++; $display("FAIL zbe_pulse got ena=%b be=%h exp 1 0", mWrEna, mBe); end
        wait_resp(gA, gB, dA, dB, n, to);
        e = 'x; if (sbq.size() > 0) e = sbq.pop_front();
        checks++; if (to || n != 0 || {gA, gB} !== 2'b10 || dA !== e.data) begin
            errors++; $display("FAIL zbe_valid got to=%0b n=%0d A=%0b B=%0b data=%h exp 0 0 1 0 %h", to, n, gA, gB, dA, e.data); end
        issue(1'b0, 1'b0, 4'd7, 32'h0, 256'h0, ok, w);
        wait_resp(gA, gB, dA, dB, n, to);
        e = 'x; if (sbq.size() > 0) e = sbq.pop_front();
        checks++; if (to || {gA, gB} !== 2'b10 || dA !== e.data || dA !== q) begin
            errors++; $display("FAIL zbe_read got to=%0b A=%0b B=%0b data=%h exp %h", to, gA, gB, dA, q); end
    endtask

    task automatic test_busy_during_exec();
        logic gA, gB; logic [255:0] dA, dB; int n; bit to; exp_t e;
        @(negedge clk);
        present(1'b0, 1'b0, 4'd3, 32'h0, 256'h0);
        #1;
        checks++; if (aBusy !== 1'b0) begin errors++; $display("FAIL bx_a_accept got busy=%b exp 0", aBusy); end
        push_exp(1'b0, 1'b0, 4'd3, 32'h0, 256'h0);
        @(negedge clk);
        aReq = 1'b0;
        present(1'b1, 1'b0, 4'd7, 32'h0, 256'h0);
        #1;
        checks++; if (bBusy !== 1'b1) begin errors++; $display("FAIL bx_b_busy_exec got %b exp 1", bBusy); end
        @(negedge clk);
        #1;
        checks++; if (bBusy !== 1'b1) begin errors++; $display("FAIL bx_b_busy_resp got %b exp 1", bBusy); end
        e = 'x; if (sbq.size() > 0) e = sbq.pop_front();
        checks++; if ({aValid, bValid} !== 2'b10 || aDout !== e.data) begin
            errors++; $display("FAIL bx_a_resp got A=%b B=%b data=%h exp 1 0 %h", aValid, bValid, aDout, e.data); end
        @(negedge clk);
        #1;
        checks++; if (bBusy !== 1'b0) begin errors++; $display("FAIL bx_b_accept got busy=%b exp 0", bBusy); end
        push_exp(1'b1, 1'b0, 4'd7, 32'h0, 256'h0);
        @(negedge clk);
        bReq = 1'b0;
        wait_resp(gA, gB, dA, dB, n, to);
        e = 'x; if (sbq.size() > 0) e = sbq.pop_front();
        checks++; if (to || {gA, gB} !== 2'b01 || dB !== e.data) begin
            errors++; $display("FAIL bx_b_resp got to=%0b A=%0b B=%0b data=%h exp %h", to, gA, gB, dB, e.data); end
    endtask

    task automatic test_round_robin();
        int vals;
        exp_t e;
        @(negedge clk); rstN = 1'b0;
        @(negedge clk); rstN = 1'b1;
        present(1'b0, 1'b0, 4'd3, 32'h0, 256'h0);
        present(1'b1, 1'b0, 4'd7, 32'h0, 256'h0);
        vals = 0;
        for (int n = 0; n < 40 && vals < 4; n++) begin
            #1;
            if (aReq && !aBusy) push_exp(1'b0, 1'b0, 4'd3, 32'h0, 256'h0);
            if (bReq && !bBusy) push_exp(1'b1, 1'b0, 4'd7, 32'h0, 256'h0);
            if (aValid || bValid) begin
                e = 'x; if (sbq.size() > 0) e = sbq.pop_front();
                checks++; if ({aValid, bValid} !== ((vals % 2 == 1) ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL rr_order_%0d got A=%b B=%b exp owner %0d", vals, aValid, bValid, vals % 2); end
                checks++; if ({aValid, bValid} !== (e.owner ? 2'b01 : 2'b10) || (e.owner ? bDout : aDout) !== e.data) begin
                    errors++; $display("FAIL rr_sb_%0d got A=%b B=%b data=%h exp owner=%0b data=%h", vals, aValid, bValid, e.owner ? bDout : aDout, e.owner, e.data); end
                vals++;
            end
            if (vals < 4) @(negedge clk);
        end
        aReq = 1'b0; bReq = 1'b0;
        checks++; if (vals != 4) begin errors++; $display("FAIL rr_count got %0d exp 4", vals); end
    endtask

    task automatic test_lone_requester();
        logic gA, gB; logic [255:0] dA, dB; int n, w; bit ok, to; exp_t e;
        issue(1'b1, 1'b0, 4'd3, 32'h0, 256'h0, ok, w);
        checks++; if (!ok || w != 0) begin errors++; $display("FAIL lone_b_accept got ok=%0b wait=%0d exp 1 0", ok, w); end
        wait_resp(gA, gB, dA, dB, n, to);
        e = 'x; if (sbq.size() > 0) e = sbq.pop_front();
        checks++; if (to || {gA, gB} !== 2'b01 || dB !== e.data) begin
            errors++; $display("FAIL lone_b_resp got to=%0b A=%0b B=%0b data=%h exp %h", to, gA, gB, dB, e.data); end
        checks++; if (sbq.size() != 0) begin errors++; $display("FAIL sb_drain got %0d exp 0", sbq.size()); end
    endtask

    task automatic test_reset_mid_exec();
        logic gA, gB; logic [255:0] dA, dB; int n, w, seen; bit ok, to; exp_t e;
        issue(1'b0, 1'b0, 4'd7, 32'h0, 256'h0, ok, w);
        #1;
        rstN = 1'b0;
        if (sbq.size() > 0) void'(sbq.pop_back());
        #1;
        checks++; if (aValid !== 1'b0 || aDout !== '0 || mWrEna !== 1'b0) begin
            errors++; $display("FAIL rmid_outputs got valid=%b data=%h ena=%b exp 0 0 0", aValid, aDout, mWrEna); end
        checks++; if (mRdAddr !== 4'd0 || mWrData !== '0) begin errors++; $display("FAIL rmid_latch got addr=%h data=%h exp 0 0", mRdAddr, mWrData); end
        seen = 0;
        repeat (3) begin
            @(negedge clk); #1;
            if (aValid || bValid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rmid_no_valid got %0d pulses exp 0", seen); end
        @(negedge clk);
        rstN = 1'b1;
        present(1'b1, 1'b0, 4'd3, 32'h0, 256'h0);
        #1;
        checks++; if (bBusy !== 1'b0) begin errors++; $display("FAIL rmid_accept got busy=%b exp 0", bBusy); end
        push_exp(1'b1, 1'b0, 4'd3, 32'h0, 256'h0);
        @(negedge clk);
        bReq = 1'b0;
        wait_resp(gA, gB, dA, dB, n, to);
        e = 'x; if (sbq.size() > 0) e = sbq.pop_front();
        checks++; if (to || n != 0 || {gA, gB} !== 2'b01 || dB !== e.data) begin
            errors++; $display("FAIL rmid_resp got to=%0b n=%0d A=%0b B=%0b data=%h exp %h", to, n, gA, gB, dB, e.data); end
    endtask

    task automatic test_fixed_priority();
        int va, vb, bFree;
        va = 0; vb = 0; bFree = 0;
        @(negedge clk);
        fAReq = 1'b1; fBReq = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (fAValid) va++;
            if (fBValid) vb++;
            if (!fBBusy) bFree++;
        end
        checks++; if (va != 10) begin errors++; $display("FAIL fp_a_grants got %0d exp 10", va); end
        checks++; if (vb != 0 || bFree != 0) begin errors++; $display("FAIL fp_b_starve got valids=%0d free=%0d exp 0 0", vb, bFree); end
        fAReq = 1'b0;
        #1;
        checks++; if (fBBusy !== 1'b0) begin errors++; $display("FAIL fp_b_after got busy=%b exp 0", fBBusy); end
        @(negedge clk);
        fBReq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial();
        test_zero_be();
        test_busy_during_exec();
        test_round_robin();
        test_lone_requester();
        test_reset_mid_exec();
        test_fixed_priority();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
